// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the 32-bit req/gnt + rvalid/rdata/err data bus.
// Holds a word-organised, byte-writable memory and answers every granted load or
// store after exactly LATENCY cycles, in acceptance order, one accept per cycle.
// Build macro DATA_MEM_RESP_STALL_EN: when defined, an 8-bit LFSR withholds the
// grant on pseudo-random cycles to stress the initiator's request-hold behaviour.
// When undefined, data_gnt_o simply follows data_req_i.

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   output logic [31:0] data_rdata_o,
   output logic [3:0]  outstanding_o
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

   // Memory contents are deliberately never reset; they survive a mid-run reset.
   logic [31:0]      memArray [DEPTH_WORDS];

   logic             stall;
   logic             accept;
   logic             inRange;
   logic [IDX_W-1:0] wordIdx;
   logic             rspFire;

   // Response pipeline: one {valid, err, rdata} entry per cycle of latency.
   logic             pipeValid [LATENCY];
   logic             pipeErr   [LATENCY];
   logic [31:0]      pipeData  [LATENCY];

   logic [3:0]       outstandingCount;

`ifdef DATA_MEM_RESP_STALL_EN
   logic [7:0] lfsr;

   // Free-running Fibonacci LFSR (x^8+x^6+x^5+x^4+1); its low bit withholds the grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // The request phase is combinational: a request is granted in the cycle it appears.
   assign data_gnt_o = data_req_i && !stall;
   assign accept     = data_req_i && !stall;

   // The full byte address is compared so that aliases above the memory are rejected.
   assign inRange = {1'b0, data_addr_i} < BYTE_LIMIT;
   assign wordIdx = data_addr_i[IDX_W+1:2];

   // Byte-lane writes for in-range stores; an all-zero byte enable is a harmless no-op.
   always_ff @(posedge clk_i) begin
      if (accept && inRange && data_we_i) begin
         for (int n = 0; n < 4; n++) begin
            if (data_be_i[n]) begin
               memArray[wordIdx][8*n +: 8] <= data_wdata_i[8*n +: 8];
            end
         end
      end
   end

   // Stage 0 captures the accept-cycle result (loads read the whole word), later stages shift.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipeValid[i] <= 1'b0;
            pipeErr[i]   <= 1'b0;
            pipeData[i]  <= '0;
         end
      end else begin
         pipeValid[0] <= accept;
         pipeErr[0]   <= accept && !inRange;
         pipeData[0]  <= (accept && inRange && !data_we_i) ? memArray[wordIdx] : 32'h0;
         for (int i = 1; i < LATENCY; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeErr[i]   <= pipeErr[i-1];
            pipeData[i]  <= pipeData[i-1];
         end
      end
   end

   assign rspFire = pipeValid[LATENCY-1];

   // In-flight count: the fixed latency keeps it within 0..LATENCY without any stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstandingCount <= 4'd0;
      end else if (accept && !rspFire) begin
         outstandingCount <= outstandingCount + 4'd1;
      end else if (!accept && rspFire) begin
         outstandingCount <= outstandingCount - 4'd1;
      end
   end

   assign data_rvalid_o = pipeValid[LATENCY-1];
   assign data_err_o    = pipeErr[LATENCY-1];
   assign data_rdata_o  = pipeData[LATENCY-1];
   assign outstanding_o = outstandingCount;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed bench for data_mem_responder. Instance dutA uses LATENCY=1 / 1024 words,
// instance dutB uses LATENCY=3 / 256 words. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge (gnt 1ns after the drive).
// With DATA_MEM_RESP_STALL_EN defined, the grant-stall scenario runs on dutA instead.

module tb_data_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   bit          monitorOn = 1'b0;

   logic        aReq, aWe, aGnt, aRvalid, aErr;
   logic [3:0]  aBe, aOut;
   logic [31:0] aAddr, aWdata, aRdata;
   logic        bReq, bWe, bGnt, bRvalid, bErr;
   logic [3:0]  bBe, bOut;
   logic [31:0] bAddr, bWdata, bRdata;

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dutA (
      .clk_i(clock), .rst_i(reset),
      .data_req_i(aReq), .data_we_i(aWe), .data_be_i(aBe), .data_addr_i(aAddr), .data_wdata_i(aWdata),
      .data_gnt_o(aGnt), .data_rvalid_o(aRvalid), .data_err_o(aErr), .data_rdata_o(aRdata),
      .outstanding_o(aOut)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dutB (
      .clk_i(clock), .rst_i(reset),
      .data_req_i(bReq), .data_we_i(bWe), .data_be_i(bBe), .data_addr_i(bAddr), .data_wdata_i(bWdata),
      .data_gnt_o(bGnt), .data_rvalid_o(bRvalid), .data_err_o(bErr), .data_rdata_o(bRdata),
      .outstanding_o(bOut)
   );

   // In-flight counts must stay within each instance's latency on every cycle.
   always @(negedge clock) begin
      if (monitorOn && !reset) begin
         checks++;
         if (aOut > 4'd1) begin errors++; $display("[TB] FAIL a_outstanding_bound got %0d max 1", aOut); end
         checks++;
         if (bOut > 4'd3) begin errors++; $display("[TB] FAIL b_outstanding_bound got %0d max 3", bOut); end
      end
   end

`ifdef DATA_MEM_RESP_STALL_EN
   logic [7:0] lfsrModel;

   // Reference LFSR, advanced on the same edges as the responder's stall generator.
   always @(posedge clock or posedge reset) begin
      if (reset) lfsrModel <= 8'hA5;
      else       lfsrModel <= {lfsrModel[6:0], lfsrModel[7] ^ lfsrModel[5] ^ lfsrModel[4] ^ lfsrModel[3]};
   end
`endif

   task automatic applyStimulus(input bit toB, input logic req, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (toB) begin
         bReq = req; bWe = we; bBe = be; bAddr = addr; bWdata = wdata;
      end else begin
         aReq = req; aWe = we; aBe = be; aAddr = addr; aWdata = wdata;
      end
   endtask

   task automatic test_reset();
      logic expGnt;
`ifdef DATA_MEM_RESP_STALL_EN
      expGnt = 1'b0;
`else
      expGnt = 1'b1;
`endif
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clock);
      checks++; if (aRvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_rvalid got %b expected 0", aRvalid); end
      checks++; if (aErr !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_err got %b expected 0", aErr); end
      checks++; if (aRdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_a_rdata got %h expected 0", aRdata); end
      checks++; if (aOut !== 4'd0) begin errors++; $display("[TB] FAIL rst_a_outstanding got %0d expected 0", aOut); end
      checks++; if (bRvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_rvalid got %b expected 0", bRvalid); end
      checks++; if (bOut !== 4'd0) begin errors++; $display("[TB] FAIL rst_b_outstanding got %0d expected 0", bOut); end
      checks++; if (aGnt !== expGnt) begin errors++; $display("[TB] FAIL rst_a_gnt_follows_req got %b expected %b", aGnt, expGnt); end
      checks++; if (bGnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_gnt_idle got %b expected 0", bGnt); end
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++; if (aGnt !== 1'b0) begin errors++; $display("[TB] FAIL a_gnt_drops got %b expected 0", aGnt); end
   endtask

   task automatic test_latency1_store_load();
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344);
      #1;
      checks++; if (aGnt !== 1'b1) begin errors++; $display("[TB] FAIL l1_store_gnt got %b expected 1", aGnt); end
      checks++; if (aRvalid !== 1'b0) begin errors++; $display("[TB] FAIL l1_early_rvalid got %b expected 0", aRvalid); end
      @(negedge clock);
      checks++; if (aRvalid !== 1'b1) begin errors++; $display("[TB] FAIL l1_store_rvalid got %b expected 1", aRvalid); end
      checks++; if (aErr !== 1'b0) begin errors++; $display("[TB] FAIL l1_store_err got %b expected 0", aErr); end
      checks++; if (aRdata !== 32'h0) begin errors++; $display("[TB] FAIL l1_store_rdata got %h expected 0", aRdata); end
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clock);
      checks++; if (aRvalid !== 1'b1) begin errors++; $display("[TB] FAIL l1_load_rvalid got %b expected 1", aRvalid); end
      checks++; if (aRdata !== 32'h11223344) begin errors++; $display("[TB] FAIL l1_raw_rdata got %h expected 11223344", aRdata); end
      checks++; if (aOut !== 4'd1) begin errors++; $display("[TB] FAIL l1_outstanding_steady got %0d expected 1", aOut); end
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'hAABBCCDD);
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 32'h10, 32'h0);
      @(negedge clock);
      checks++; if (aRdata !== 32'h1122CC44) begin errors++; $display("[TB] FAIL l1_byte_lane_rdata got %h expected 1122CC44", aRdata); end
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF);
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clock);
      checks++; if (aRdata !== 32'h1122CC44) begin errors++; $display("[TB] FAIL l1_be_zero_rdata got %h expected 1122CC44", aRdata); end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clock);
      checks++; if (aRvalid !== 1'b0) begin errors++; $display("[TB] FAIL l1_idle_rvalid got %b expected 0", aRvalid); end
      checks++; if (aOut !== 4'd0) begin errors++; $display("[TB] FAIL l1_idle_outstanding got %0d expected 0", aOut); end
   endtask

   task automatic test_out_of_range_l1();
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 32'h1010, 32'h12345678);
      @(negedge clock);
      checks++; if (aErr !== 1'b1) begin errors++; $display("[TB] FAIL l1_oor_store_err got %b expected 1", aErr); end
      checks++; if (aRvalid !== 1'b1) begin errors++; $display("[TB] FAIL l1_oor_store_rvalid got %b expected 1", aRvalid); end
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clock);
      checks++; if (aRdata !== 32'h1122CC44) begin errors++; $display("[TB] FAIL l1_oor_no_alias_write got %h expected 1122CC44", aRdata); end
      checks++; if (aErr !== 1'b0) begin errors++; $display("[TB] FAIL l1_inrange_err got %b expected 0", aErr); end
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h1010, 32'h0);
      @(negedge clock);
      checks++; if (aErr !== 1'b1) begin errors++; $display("[TB] FAIL l1_oor_load_err got %b expected 1", aErr); end
      checks++; if (aRdata !== 32'h0) begin errors++; $display("[TB] FAIL l1_oor_load_rdata got %h expected 0", aRdata); end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic        expValid;
      logic [3:0]  expOut;
      logic [31:0] expData;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 32'(i * 4), 32'(i + 1));
      end
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(negedge clock);
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clock);
         expValid = (c >= 3) && (c <= 5);
         expData  = expValid ? 32'(c - 2) : 32'h0;
         expOut   = (c <= 3) ? 4'(c) : 4'(6 - c);
         checks++; if (bRvalid !== expValid) begin errors++; $display("[TB] FAIL b2b_rvalid_c%0d got %b expected %b", c, bRvalid, expValid); end
         checks++; if (bOut !== expOut) begin errors++; $display("[TB] FAIL b2b_outstanding_c%0d got %0d expected %0d", c, bOut, expOut); end
         if (expValid) begin
            checks++; if (bRdata !== expData) begin errors++; $display("[TB] FAIL b2b_rdata_c%0d got %h expected %h", c, bRdata, expData); end
         end
         if (c < 3) applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'(c * 4), 32'h0);
         else       applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
   endtask

   task automatic test_out_of_range();
      logic        reqWe   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] reqAddr [5] = '{32'h400, 32'h400, 32'h3FC, 32'h3FC, 32'h0};
      logic [31:0] reqData [5] = '{32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
      logic        expErr  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] expData [5] = '{32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h1};
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (c >= 3) begin
            checks++; if (bRvalid !== 1'b1) begin errors++; $display("[TB] FAIL oor_rvalid_r%0d got %b expected 1", c - 3, bRvalid); end
            checks++; if (bErr !== expErr[c-3]) begin errors++; $display("[TB] FAIL oor_err_r%0d got %b expected %b", c - 3, bErr, expErr[c-3]); end
            checks++; if (bRdata !== expData[c-3]) begin errors++; $display("[TB] FAIL oor_rdata_r%0d got %h expected %h", c - 3, bRdata, expData[c-3]); end
         end else begin
            checks++; if (bRvalid !== 1'b0) begin errors++; $display("[TB] FAIL oor_early_rvalid_c%0d got %b expected 0", c, bRvalid); end
         end
         if (c < 5) begin
            applyStimulus(1'b1, 1'b1, reqWe[c], 4'hF, reqAddr[c], reqData[c]);
            #1;
            checks++; if (bGnt !== 1'b1) begin errors++; $display("[TB] FAIL oor_gnt_c%0d got %b expected 1", c, bGnt); end
         end else begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      #1;
      checks++; if (bOut !== 4'd0) begin errors++; $display("[TB] FAIL midrst_outstanding got %0d expected 0", bOut); end
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         checks++; if (bRvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ghost_rvalid_c%0d got %b expected 0", c, bRvalid); end
         checks++; if (bOut !== 4'd0) begin errors++; $display("[TB] FAIL midrst_outstanding_c%0d got %0d expected 0", c, bOut); end
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         checks++; if (bRvalid !== (c == 3)) begin errors++; $display("[TB] FAIL midrst_after_rvalid_c%0d got %b expected %b", c, bRvalid, (c == 3)); end
      end
      checks++; if (bRdata !== 32'h3) begin errors++; $display("[TB] FAIL midrst_after_rdata got %h expected 3", bRdata); end
   endtask

`ifdef DATA_MEM_RESP_STALL_EN
   task automatic test_stall();
      logic [31:0] expQ [$];
      logic [31:0] expVal;
      int          grants = 0;
      int          rsps   = 0;
      int          idx    = 0;
      for (int c = 0; c < 68; c++) begin
         @(negedge clock);
         if (aRvalid === 1'b1) begin
            rsps++;
            checks++;
            if (expQ.size() == 0) begin
               errors++; $display("[TB] FAIL stall_extra_rvalid got rdata %h expected none", aRdata);
            end else begin
               expVal = expQ.pop_front();
               if (aRdata !== expVal) begin errors++; $display("[TB] FAIL stall_order_rdata got %h expected %h", aRdata, expVal); end
            end
         end
         if (c < 64) begin
            applyStimulus(1'b0, 1'b1, (idx < 8), 4'hF, 32'((idx % 8) * 4), 32'h5A000000 + 32'(idx));
            #1;
            checks++;
            if (aGnt !== !lfsrModel[0]) begin errors++; $display("[TB] FAIL stall_gnt_c%0d got %b expected %b", c, aGnt, !lfsrModel[0]); end
            if (aGnt === 1'b1) begin
               expQ.push_back((idx < 8) ? 32'h0 : 32'h5A000000 + 32'(idx % 8));
               grants++;
               idx++;
            end
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         end
      end
      checks++; if (rsps !== grants) begin errors++; $display("[TB] FAIL stall_rsp_count got %0d expected %0d", rsps, grants); end
      checks++; if (grants < 9) begin errors++; $display("[TB] FAIL stall_grant_count got %0d expected at least 9", grants); end
   endtask
`endif

   // Scenario sequence; the summary line is the last thing printed.
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      test_reset();
      monitorOn = 1'b1;
`ifdef DATA_MEM_RESP_STALL_EN
      test_stall();
`else
      test_latency1_store_load();
      test_out_of_range_l1();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
`endif
      monitorOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the 32-bit data bus protocol driven by the scalar/vector data arbiter: req/gnt request phase, rvalid/rdata/err response phase, in-order responses. It holds a word-organised, byte-writable SRAM model and returns every granted request (load or store) after a fixed, parameterisable latency. It is the data memory for core-plus-vector-unit simulation and FPGA builds, and the protocol-compliant target for arbiter verification.

## Interface
- DEPTH_WORDS, 1024: memory size in 32-bit words; power of two, 16..65536.
- LATENCY, 1: cycles from the accept cycle to rvalid; 1..8.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- data_req_i  input  1  request valid.
- data_we_i  input  1  1 = store, 0 = load.
- data_be_i  input  4  byte enables, bit n = byte lane n.
- data_addr_i  input  32  byte address; bits [1:0] ignored.
- data_wdata_i  input  32  store data.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid; one cycle per accepted request.
- data_err_o  output  1  response error, qualified by rvalid.
- data_rdata_o  output  32  load data, qualified by rvalid.
- outstanding_o  output  4  accepted requests not yet answered, 0..LATENCY.

## Operation
- Accept cycle: data_req_i && data_gnt_o.
- data_gnt_o = data_req_i && !stall. Stall is always 0 unless the configuration macro is defined. There is no capacity stall because the fixed latency bounds in-flight requests to LATENCY.
- Word index = data_addr_i[31:2]. Out of range when data_addr_i >= DEPTH_WORDS*4.
- In-range store: on the accept edge, each byte lane with be[n]=1 is written with wdata[8n+7:8n]. Other lanes are unchanged. be=0000 is a legal no-op write.
- In-range load: the full word is read on the accept edge, and be is ignored. rdata returns all 4 bytes.
- Out-of-range access: there is no memory write. The response has err=1 and rdata=0.
- Store response: rvalid=1, err=0 (or 1 if out of range), rdata=0.
- Response pipeline: LATENCY stages, each holding {valid, err, rdata}. It shifts every cycle. Stage 0 loads the accept-cycle result, or valid=0 if there is no accept.
- outputs = last stage. Outputs are registered, with no combinational path from inputs.
- outstanding counter:
  - +1 on accept, -1 on rvalid, unchanged when both occur in the same cycle.
  - Never exceeds LATENCY and never underflows. The bench asserts both.
- Memory contents are not reset and are X after power-up. The bench preloads them via hierarchical write or $readmemh.

## Timing
- rvalid asserts exactly LATENCY cycles after the accept cycle. Accept in cycle N gives a response in cycle N+LATENCY.
- Throughput: one accept per cycle, sustained indefinitely.
- Responses come in acceptance order, with no gaps beyond the request gaps.
- Read-after-write:
  - A store accepted in cycle N is visible to a load accepted in cycle N+1.
  - Only one request exists per cycle, so same-cycle hazards do not occur.
- There is no response backpressure: the initiator must always accept rvalid.
- Reset values: data_gnt_o follows data_req_i combinationally (or 0 while stalled). rvalid=0, err=0, rdata=0, outstanding=0, and all pipeline valids are 0.
- Reset mid-operation: all in-flight responses are discarded and never produce rvalid. Memory writes already committed persist.
- The request phase is combinational. Initiators must not make data_req_i depend on data_gnt_o.

## Configuration
- DATA_MEM_RESP_STALL_EN defined: grant-stall injection for protocol stress.
  - 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, reset to 8'hA5, advancing every cycle.
  - stall = lfsr[0].
  - While stalled, data_gnt_o=0, with no write and no pipeline entry. The initiator must hold the request stable.
- DATA_MEM_RESP_STALL_EN undefined: the LFSR is absent and data_gnt_o = data_req_i.

## Test plan
- LATENCY=1: store 0x11223344 to 0x10 with be=1111, then load 0x10 in the next cycle.
  - Store rvalid one cycle after its accept, err=0.
  - Load rvalid one cycle after its accept, rdata=0x11223344.
- After the above, store 0xAABBCCDD to 0x10 with be=0010, then load 0x10 -> rdata=0x1122CC44.
- LATENCY=3: back-to-back loads of 0x0, 0x4, 0x8 preloaded with 1, 2, 3, accepted in cycles 0-2.
  - rvalid in cycles 3, 4, 5 with rdata 1, 2, 3.
  - outstanding_o peaks at 3.
- DEPTH_WORDS=256: store to 0x400 -> granted, rvalid with err=1 and rdata=0; a following load of 0x0 returns its preloaded value unchanged.
- LATENCY=3: load accepted in cycle 0, rst_i high in cycle 1 -> no rvalid ever and outstanding_o=0; a load accepted after reset returns correct data in 3 cycles.
- DATA_MEM_RESP_STALL_EN defined: data_req_i held high for 64 cycles.
  - data_gnt_o equals !lfsr[0] every cycle.
  - Number of rvalids equals number of grants.
  - Responses are in order.
